// File: rtl/croc_pad_in_cond.sv
// Input pad conditioner: per-channel synchronizer, stable-count glitch filter, edge pulses,
// sticky edge events and a combined interrupt. Optional per-channel filter bypass: CROC_PAD_IN_COND_BYPASS_EN.
module croc_pad_in_cond #(
  parameter int unsigned      NumIn        = 3,
  parameter int unsigned      SyncStages   = 2,
  parameter int unsigned      FilterCycles = 4,
  parameter logic [NumIn-1:0] ResetVal     = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NumIn-1:0] pad_i,
  input  logic [NumIn-1:0] rise_en_i,
  input  logic [NumIn-1:0] fall_en_i,
  input  logic [NumIn-1:0] evt_clr_i,
  input  logic [NumIn-1:0] evt_mask_i,
`ifdef CROC_PAD_IN_COND_BYPASS_EN
  input  logic [NumIn-1:0] bypass_i,
`endif
  output logic [NumIn-1:0] level_o,
  output logic [NumIn-1:0] rise_o,
  output logic [NumIn-1:0] fall_o,
  output logic [NumIn-1:0] evt_o,
  output logic             irq_o
);

  localparam int unsigned     CntW    = $clog2(FilterCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);

  logic [SyncStages-1:0][NumIn-1:0] sync_q;
  logic [NumIn-1:0]                 sync;
  logic [NumIn-1:0][CntW-1:0]       cnt_q, cnt_d;
  logic [NumIn-1:0]                 level_q, level_d;
  logic [NumIn-1:0]                 rise_q, rise_d;
  logic [NumIn-1:0]                 fall_q, fall_d;
  logic [NumIn-1:0]                 evt_q, evt_d;
  logic                             irq_q, irq_d;
  logic [NumIn-1:0]                 byp;

`ifdef CROC_PAD_IN_COND_BYPASS_EN
  assign byp = bypass_i;
`else
  assign byp = '0;
`endif

  assign sync = sync_q[SyncStages-1];

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < NumIn; i++) begin
      if (byp[i]) begin
        level_d[i] = sync[i];
        cnt_d[i]   = '0;
      end else if (sync[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        level_d[i] = sync[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    // Pulses are computed from the next level so they register alongside it.
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
    evt_d  = (evt_q & ~evt_clr_i) | (rise_d & rise_en_i) | (fall_d & fall_en_i);
    irq_d  = |(evt_q & evt_mask_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= {SyncStages{ResetVal}};
      cnt_q   <= '0;
      level_q <= ResetVal;
      rise_q  <= '0;
      fall_q  <= '0;
      evt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SyncStages-2:0], pad_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      evt_q   <= evt_d;
      irq_q   <= irq_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign evt_o   = evt_q;
  assign irq_o   = irq_q;

endmodule
